// File: rtl/stage_pkg.sv
// Shared types and constants for the pipeline stage register.
// The EMPTY/FULL/SKID encoding is common to the FSM and to the occupancy decode.
package stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_N_CH   = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/stage_slot.sv
// Load-enabled {pc, instr, data} holding register, zeroed by async reset.
// Latency: the value is visible one cycle after ld_i. A clear takes priority over a load and affects only instr.
module stage_slot
    import stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_i,
    input  logic                   clr_instr_i,
    input  logic [DATA_W-1:0]      pc_i,
    input  logic [DATA_W-1:0]      instr_i,
    input  logic [N_CH*DATA_W-1:0] data_i,
    output logic [DATA_W-1:0]      pc_o,
    output logic [DATA_W-1:0]      instr_o,
    output logic [N_CH*DATA_W-1:0] data_o
);

    logic [DATA_W-1:0]      pc_q;
    logic [DATA_W-1:0]      instr_q;
    logic [N_CH*DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= '0;
            data_q  <= '0;
        end else if (clr_instr_i) begin
            instr_q <= DATA_W'(NOP_INSTR);
        end else if (ld_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            data_q  <= data_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/stage_reg.sv
// Valid/ready pipeline stage register: one cycle from accept to out_valid; outputs hold while stalled.
// Building with STAGE_REG_SKID_EN adds a skid slot and a registered in_ready; otherwise in_ready is combinational.
module stage_reg
    import stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]      in_instr,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_pc,
    output logic [DATA_W-1:0]      out_instr,
    output logic [N_CH*DATA_W-1:0] out_data,
    input  logic                   out_ready,
    output logic [1:0]             occupancy
);

    state_e state_q, state_d;
    logic   main_ld;

    logic [DATA_W-1:0]      main_pc_d;
    logic [DATA_W-1:0]      main_instr_d;
    logic [N_CH*DATA_W-1:0] main_data_d;

`ifdef STAGE_REG_SKID_EN
    logic                   skid_ld;
    logic                   main_from_skid;
    logic                   in_ready_q;
    logic [DATA_W-1:0]      skid_pc;
    logic [DATA_W-1:0]      skid_instr;
    logic [N_CH*DATA_W-1:0] skid_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_valid) state_d = FULL;
                FULL: begin
                    if (!in_valid && out_ready) state_d = EMPTY;
`ifdef STAGE_REG_SKID_EN
                    else if (in_valid && !out_ready) state_d = SKID;
`endif
                end
`ifdef STAGE_REG_SKID_EN
                SKID: if (out_ready) state_d = FULL;
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        occupancy = 2'd0;
        main_ld   = 1'b0;
`ifdef STAGE_REG_SKID_EN
        skid_ld        = 1'b0;
        main_from_skid = (state_q == SKID);
`endif
        case (state_q)
            FULL:    occupancy = 2'd1;
`ifdef STAGE_REG_SKID_EN
            SKID:    occupancy = 2'd2;
`endif
            default: occupancy = 2'd0;
        endcase
        // A flush drops any same-cycle transfer-in, so no slot may load.
        if (!flush) begin
            case (state_q)
                EMPTY: main_ld = in_valid;
                FULL: begin
                    main_ld = in_valid && out_ready;
`ifdef STAGE_REG_SKID_EN
                    skid_ld = in_valid && !out_ready;
`endif
                end
`ifdef STAGE_REG_SKID_EN
                SKID: main_ld = out_ready;
`endif
                default: main_ld = 1'b0;
            endcase
        end
    end

`ifdef STAGE_REG_SKID_EN
    // Ready comes straight from a flop so no combinational path reaches upstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != SKID);
        end
    end

    assign in_ready     = in_ready_q;
    assign main_pc_d    = main_from_skid ? skid_pc    : in_pc;
    assign main_instr_d = main_from_skid ? skid_instr : in_instr;
    assign main_data_d  = main_from_skid ? skid_data  : in_data;

    stage_slot #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH)
    ) u_skid (
        .clk         (clk),
        .rst         (reset),
        .ld_i        (skid_ld),
        .clr_instr_i (1'b0),
        .pc_i        (in_pc),
        .instr_i     (in_instr),
        .data_i      (in_data),
        .pc_o        (skid_pc),
        .instr_o     (skid_instr),
        .data_o      (skid_data)
    );
`else
    assign in_ready     = !out_valid || out_ready;
    assign main_pc_d    = in_pc;
    assign main_instr_d = in_instr;
    assign main_data_d  = in_data;
`endif

    stage_slot #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH)
    ) u_main (
        .clk         (clk),
        .rst         (reset),
        .ld_i        (main_ld),
        .clr_instr_i (flush),
        .pc_i        (main_pc_d),
        .instr_i     (main_instr_d),
        .data_i      (main_data_d),
        .pc_o        (out_pc),
        .instr_o     (out_instr),
        .data_o      (out_data)
    );

endmodule

// File: tb/tb_stage_reg.sv
// Bench for stage_reg: queue-based reference model checked every cycle, plus literal directed checks.
module tb_stage_reg;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int PW = DW * NC;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_instr;
    logic [PW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_instr;
    logic [PW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    occupancy;

    stage_reg #(
        .DATA_W (DW),
        .N_CH   (NC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
        logic [PW-1:0] data;
    } ent_t;

    // Model: the held entries in arrival order, plus the last values shown on the outputs.
    ent_t          mq[$];
    logic [DW-1:0] m_pc;
    logic [DW-1:0] m_instr;
    logic [PW-1:0] m_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
`ifdef STAGE_REG_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    task automatic m_reset();
        mq.delete();
        m_pc    = '0;
        m_instr = '0;
        m_data  = '0;
    endtask

    // Advance the model by one clock edge using the inputs that were applied before it.
    task automatic m_step();
        bit   ir;
        bit   ov;
        ent_t e;
        ir = m_in_ready();
        ov = (mq.size() > 0);
        if (flush) begin
            mq.delete();
            m_instr = '0;
        end else begin
            if (ov && out_ready) void'(mq.pop_front());
            if (in_valid && ir) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                e.data  = in_data;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) begin
            m_pc    = mq[0].pc;
            m_instr = mq[0].instr;
            m_data  = mq[0].data;
        end
    endtask

    function automatic logic [PW-1:0] rnd_data();
        logic [PW-1:0] d;
        d = '0;
        for (int k = 0; k < NC; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                        input logic [PW-1:0] d, input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        m_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("in_ready",  PW'(in_ready),  PW'(m_in_ready()));
            chk("out_valid", PW'(out_valid), PW'(mq.size() > 0));
            chk("occupancy", PW'(occupancy), PW'(mq.size()));
            chk("out_pc",    PW'(out_pc),    PW'(m_pc));
            chk("out_instr", PW'(out_instr), PW'(m_instr));
            chk("out_data",  out_data,       m_data);
        end
    end

    initial begin
        logic [DW-1:0] got[$];
        int            idx;
        int            cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_reset();
        #1;
        chk("rst_out_valid", PW'(out_valid), PW'(0));
        chk("rst_occupancy", PW'(occupancy), PW'(0));
        chk("rst_in_ready",  PW'(in_ready),  PW'(1));
        chk("rst_out_pc",    PW'(out_pc),    PW'(0));
        chk("rst_out_instr", PW'(out_instr), PW'(0));
        chk("rst_out_data",  out_data,       PW'(0));
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // First transfer: one-cycle latency from an empty stage.
        step(1'b1, 32'h3000, 32'h2408_0001, rnd_data(), 1'b1, 1'b0);
        chk("first_valid", PW'(out_valid), PW'(1));
        chk("first_pc",    PW'(out_pc),    PW'(32'h3000));
        chk("first_instr", PW'(out_instr), PW'(32'h2408_0001));
        chk("first_occ",   PW'(occupancy), PW'(1));

`ifdef STAGE_REG_SKID_EN
        step(1'b1, 32'h3004, 32'h2409_0002, rnd_data(), 1'b0, 1'b0);
        chk("skid_occ",      PW'(occupancy), PW'(2));
        chk("skid_in_ready", PW'(in_ready),  PW'(0));
        chk("skid_hold_pc",  PW'(out_pc),    PW'(32'h3000));
        step(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        chk("drain_pc",  PW'(out_pc),    PW'(32'h3004));
        chk("drain_occ", PW'(occupancy), PW'(1));
        step(1'b1, 32'h3008, 32'h240A_0003, rnd_data(), 1'b0, 1'b0);
        chk("skid2_occ", PW'(occupancy), PW'(2));
`else
        in_valid  = 1'b1;
        in_pc     = 32'h3004;
        in_instr  = 32'h2409_0002;
        in_data   = rnd_data();
        out_ready = 1'b0;
        #1;
        chk("comb_rdy_low", PW'(in_ready), PW'(0));
        out_ready = 1'b1;
        #1;
        chk("comb_rdy_high", PW'(in_ready), PW'(1));
        @(posedge clk);
        m_step();
        #1;
        chk("reload_pc",  PW'(out_pc),    PW'(32'h3004));
        chk("reload_occ", PW'(occupancy), PW'(1));
`endif

        // Flush with a same-cycle input: input dropped, NOP shown, pc held.
        step(1'b1, 32'h300C, 32'h240B_0004, rnd_data(), 1'b1, 1'b1);
        chk("flush_valid",    PW'(out_valid), PW'(0));
        chk("flush_instr",    PW'(out_instr), PW'(0));
        chk("flush_occ",      PW'(occupancy), PW'(0));
        chk("flush_in_ready", PW'(in_ready),  PW'(1));
        chk("flush_hold_pc",  PW'(out_pc),    PW'(32'h3004));

        // Asynchronous reset between edges while FULL.
        step(1'b1, 32'h3100, 32'h1234_5678, rnd_data(), 1'b0, 1'b0);
        chk("pre_arst_valid", PW'(out_valid), PW'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", PW'(out_valid), PW'(0));
        chk("arst_pc",    PW'(out_pc),    PW'(0));
        chk("arst_instr", PW'(out_instr), PW'(0));
        chk("arst_data",  out_data,       PW'(0));
        chk("arst_occ",   PW'(occupancy), PW'(0));
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Ordered stream under random backpressure: no gap, no duplicate.
        idx = 0;
        cyc = 0;
        while ((got.size() < 16) && (cyc < 400)) begin
            in_valid  = (idx < 16) && ($urandom_range(0, 3) != 0);
            in_pc     = DW'(32'h3000 + idx * 4);
            in_instr  = $urandom;
            in_data   = rnd_data();
            out_ready = $urandom_range(0, 1) != 0;
            flush     = 1'b0;
            #1;
            if (out_valid && out_ready) got.push_back(out_pc);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            m_step();
            #1;
            cyc++;
        end
        chk("stream_count", PW'(got.size()), PW'(16));
        for (int i = 0; i < got.size() && i < 16; i++) begin
            chk("stream_pc", PW'(got[i]), PW'(32'h3000 + i * 4));
        end

        // Random traffic with occasional flushes, checked every cycle by the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 2) != 0, $urandom, $urandom, rnd_data(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_reg.md
STAGE_REG -- requirements
Module: stage_reg

Interface
REQ-001 Param DATA_W, default 32, width of every payload channel, PC and instruction.
REQ-002 Param N_CH, default 4, payload channels carried alongside PC/instr; legal range 1..8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream stage presents a valid instruction.
REQ-006 in_ready  output  1  stage accepts input this cycle; registered when STAGE_REG_SKID_EN is defined.
REQ-007 in_pc, in_instr  input  DATA_W each  PC and instruction word of upstream stage.
REQ-008 in_data  input  N_CH*DATA_W  packed payload, channel k at bits [k*DATA_W +: DATA_W].
REQ-009 flush  input  1  discard all held contents, e.g. on branch or exception.
REQ-010 out_valid, out_pc, out_instr, out_data  output  1/DATA_W/DATA_W/N_CH*DATA_W  registered stage contents.
REQ-011 out_ready  input  1  downstream stage consumes the output this cycle.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 Transfer-in occurs when in_valid&in_ready; transfer-out occurs when out_valid&out_ready.
REQ-014 Latency is exactly one cycle from transfer-in to out_valid when the stage is empty.
REQ-015 FSM states are EMPTY, FULL and SKID, with SKID reachable only when STAGE_REG_SKID_EN is defined.
REQ-016 EMPTY: in_valid loads the main register and moves to FULL; otherwise it holds.
REQ-017 FULL: in_valid&out_ready reloads main and stays FULL; !in_valid&out_ready moves to EMPTY; in_valid&!out_ready moves to SKID, loading skid (macro on) or is impossible (macro off, because in_ready=0); otherwise it holds.
REQ-018 SKID: in_ready=0; out_ready copies skid into main and moves to FULL.
REQ-019 Outputs hold their previous value bit-exact while out_valid&!out_ready, the stall case.
REQ-020 Flush has the highest priority: the next state is EMPTY, out_valid=0, out_instr=0 (NOP), the skid is discarded and any same-cycle transfer-in is dropped; other output fields hold.
REQ-021 occupancy is 0 in EMPTY, 1 in FULL and 2 in SKID.
REQ-022 No data is lost or duplicated under any sequence of in_valid and out_ready when no flush occurs.

Reset
REQ-023 While reset is high: state EMPTY, out_valid=0, out_pc=0, out_instr=0, out_data=0, skid contents 0, occupancy=0, in_ready=1.
REQ-024 Reset asserted mid-operation takes effect immediately and asynchronously; deassertion is applied synchronously to clk.

Configuration
REQ-025 The macro STAGE_REG_SKID_EN controls the skid buffer.
REQ-026 Defined: a two-entry skid buffer is present, in_ready=(state!=SKID) is registered, and full throughput is achieved with no combinational ready path.
REQ-027 Undefined: a single entry is present, in_ready=!out_valid|out_ready is combinational, the SKID state and skid storage are absent, and occupancy never exceeds 1.

Structure
REQ-028 Shared package stage_pkg holds the state enum (EMPTY/FULL/SKID), the NOP constant 32'h0000_0000 and the default DATA_W/N_CH.
REQ-029 Sub-module stage_slot (load-enabled payload register {pc,instr,data} with async reset) is instantiated once as main and once as skid, the skid only under the macro.

Verification
REQ-030 Reset then in_valid=1, in_pc=32'h3000, in_instr=32'h2408_0001, out_ready=1 -> next cycle out_valid=1, out_pc=32'h3000, occupancy=1.
REQ-031 Macro on: FULL with out_ready=0 and in_valid=1 carrying pc 32'h3004 -> occupancy=2, in_ready=0 next cycle; out_ready=1 -> 32'h3000 then 32'h3004 emerge in order.
REQ-032 Stream pc 32'h3000..32'h303C with random out_ready -> the output sequence equals the input sequence with no gap or duplicate.
REQ-033 Assert flush in SKID with in_valid=1 -> next cycle out_valid=0, out_instr=0, occupancy=0, in_ready=1.
REQ-034 Assert reset asynchronously between clock edges while FULL -> out_valid=0 and all outputs 0 before the next edge.
REQ-035 Macro off, out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle.
